// File: rtl/macguffin_round_ctrl.sv
// Round sequencer for the iterative MacGuffin core. It holds one block in flight,
// fetches one round key per round and feeds the shared single-round datapath.
module macguffin_round_ctrl #(
  parameter int ROUNDS  = 32,
  parameter int BLOCK_W = 64,
  parameter int KEY_W   = 48,
  parameter int AW      = $clog2(ROUNDS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_valid,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_block,
  input  logic               in_decrypt,
  output logic [AW-1:0]      rk_addr,
  input  logic [KEY_W-1:0]   rk_data,
  output logic [BLOCK_W-1:0] dp_state,
  output logic [KEY_W-1:0]   dp_key,
  output logic               dp_decrypt,
  input  logic [BLOCK_W-1:0] dp_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_block,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ROUND,
    DONE
  } fsm_e;

  localparam logic [AW-1:0] LAST = AW'(ROUNDS - 1);

  fsm_e               fsm_q, fsm_d;
  logic [BLOCK_W-1:0] state_q, state_d;
  logic [AW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [AW-1:0]      addr_step;
  logic               dec_q, dec_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               accept;

  assign in_ready = (fsm_q == IDLE) && key_valid;
  assign accept   = in_valid && in_ready;

  // Key address walks toward the last key of the direction and parks there.
  always_comb begin
    if (dec_q) addr_step = (addr_q == '0)   ? addr_q : addr_q - AW'(1);
    else       addr_step = (addr_q == LAST) ? addr_q : addr_q + AW'(1);
  end

  always_comb begin
    // NOTE: every target gets a hold default first so no path infers a latch.
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dec_d   = dec_q;
    unique case (fsm_q)
      IDLE: begin
        if (accept) begin
          fsm_d   = FETCH;
          state_d = in_block;
          dec_d   = in_decrypt;
          cnt_d   = '0;
          addr_d  = in_decrypt ? LAST : '0;
        end
      end
      FETCH: begin
        fsm_d  = ROUND;
        addr_d = addr_step;
      end
      ROUND: begin
        state_d = dp_result;
        addr_d  = addr_step;
        if (cnt_q == LAST) begin
          cnt_d = '0;
          fsm_d = DONE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
    out_valid_d = (fsm_d == DONE);
    busy_d      = (fsm_d == FETCH) || (fsm_d == ROUND);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      dec_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      dec_q       <= dec_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign rk_addr    = addr_q;
  assign dp_state   = state_q;
  assign dp_key     = rk_data;
  assign dp_decrypt = dec_q;
  assign out_block  = state_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;

endmodule
